fetch_sequencer: RTL and testbench

Instruction-fetch controller for the MIPS core. Owns the program counter and drives the address of the combinational instruction memory (byte address in, 32-bit word out, same cycle). Registers the fetched word into the IF/ID output with a valid flag. Handles stall, branch/jump redirect, halt-on-sentinel and bad-address trapping.

---
 rtl/fetch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Instruction-fetch controller. Owns the program counter, drives the byte
//   address of a combinational instruction memory and registers the returned
//   word into the IF/ID stage together with its PC+4 and a valid flag.
//   Handles stall, branch/jump redirect, halt on a sentinel instruction and
//   trapping of misaligned / out-of-range fetch addresses.
//
// Ports
//   Clk          rising-edge clock
//   Reset        asynchronous, active-high reset
//   Adress       byte address to instruction memory (always the current PC)
//   Word         instruction returned by memory for Adress, same cycle
//   Stall        hold PC and IF/ID contents
//   Branch       taken-branch redirect request (beats Jump)
//   Branch_pc    branch target
//   Jump         jump redirect request
//   Jump_pc      jump target
//   Instr        IF/ID instruction
//   Pc_plus4     IF/ID PC+4 belonging to Instr
//   Instr_valid  Instr holds a real instruction
//   Halted       registered "in HALT" flag
//   Fault        registered "in FAULT" flag
//   Fault_pc     address that caused the fault, captured on FAULT entry
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned MEM_BYTES    = 128,
    parameter logic [31:0] HALT_WORD    = 32'hFC00_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] Adress,
    input  logic [31:0] Word,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [31:0] Branch_pc,
    input  logic        Jump,
    input  logic [31:0] Jump_pc,
    output logic [31:0] Instr,
    output logic [31:0] Pc_plus4,
    output logic        Instr_valid,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] Fault_pc
);

    // Highest legal word address inside the instruction memory.
    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] fault_pc_n;
    ifid_t       ifid, ifid_n;
    logic [31:0] pc_inc;
    logic        pc_bad;

    assign Adress      = pc;
    assign Instr       = ifid.instr;
    assign Pc_plus4    = ifid.pc_plus4;
    assign Instr_valid = ifid.valid;

    // 32-bit modulo increment; a wrapped PC is still caught by pc_bad.
    assign pc_inc = pc + 32'd4;

    // Redirect targets are not screened on capture; they are screened here,
    // the cycle they become the PC.
    assign pc_bad = (pc[1:0] != 2'b00) || (pc > LAST_ADDR);

    // -----------------------------------------------------------------------
    // State register and IF/ID register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= BOOT;
            pc       <= RESET_VECTOR;
            ifid     <= '0;
            Fault_pc <= '0;
            Halted   <= 1'b0;
            Fault    <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ifid     <= ifid_n;
            Fault_pc <= fault_pc_n;
            // Status flags follow the state with one cycle of delay, so they
            // rise the cycle after entry and can never both be set.
            Halted   <= (state == HALT);
            Fault    <= (state == FAULT);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state / datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ifid_n     = ifid;
        fault_pc_n = Fault_pc;

        case (state)
            BOOT: begin
                // One settling cycle: no fetch is registered.
                state_n = RUN;
            end

            RUN: begin
                if (pc_bad) begin
                    state_n      = FAULT;
                    fault_pc_n   = pc;
                    ifid_n.valid = 1'b0;
                end else if (Branch) begin
                    // Redirects insert a bubble even while stalled.
                    pc_n         = Branch_pc;
                    ifid_n.valid = 1'b0;
                end else if (Jump) begin
                    pc_n         = Jump_pc;
                    ifid_n.valid = 1'b0;
                end else if (Stall) begin
                    // Everything holds.
                end else begin
                    ifid_n.instr    = Word;
                    ifid_n.pc_plus4 = pc_inc;
                    ifid_n.valid    = 1'b1;
                    // The sentinel itself is delivered once; PC stays on it.
                    if (Word == HALT_WORD) begin
                        state_n = HALT;
                    end else begin
                        pc_n = pc_inc;
                    end
                end
            end

            HALT: begin
                ifid_n.valid = 1'b0;
            end

            FAULT: begin
                ifid_n.valid = 1'b0;
            end

            default: begin
                state_n = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] HALTW = 32'hFC00_0000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Adress;
    logic [31:0] Word;
    logic        Stall = 1'b0;
    logic        Branch = 1'b0;
    logic [31:0] Branch_pc = '0;
    logic        Jump = 1'b0;
    logic [31:0] Jump_pc = '0;
    logic [31:0] Instr;
    logic [31:0] Pc_plus4;
    logic        Instr_valid;
    logic        Halted;
    logic        Fault;
    logic [31:0] Fault_pc;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [0:31];

    fetch_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .MEM_BYTES   (128),
        .HALT_WORD   (HALTW)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Adress     (Adress),
        .Word       (Word),
        .Stall      (Stall),
        .Branch     (Branch),
        .Branch_pc  (Branch_pc),
        .Jump       (Jump),
        .Jump_pc    (Jump_pc),
        .Instr      (Instr),
        .Pc_plus4   (Pc_plus4),
        .Instr_valid(Instr_valid),
        .Halted     (Halted),
        .Fault      (Fault),
        .Fault_pc   (Fault_pc)
    );

    always #5 Clk = ~Clk;

    // Combinational instruction memory; garbage outside the legal window.
    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a < 32'd128 && a[1:0] == 2'b00) return mem[a[6:2]];
        return 32'hDEAD_BEEF;
    endfunction

    assign Word = rd(Adress);

    // ---------------- reference model ----------------
    // Phase of the sequencer as named in the behaviour description.
    string       m_phase;
    string       m_prev;
    logic [31:0] m_pc, m_instr, m_pp4, m_fpc;
    logic        m_valid, m_halted, m_fault;

    task automatic model_reset();
        m_phase = "BOOT"; m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_fpc = 32'h0;
    endtask

    task automatic model_edge();
        logic [31:0] w;
        if (Reset) begin
            model_reset();
            return;
        end
        m_prev = m_phase;
        w = rd(m_pc);
        if (m_phase == "BOOT") begin
            m_phase = "RUN";
        end else if (m_phase == "RUN") begin
            if ((m_pc % 4) != 0 || m_pc > 124) begin
                m_phase = "FAULT"; m_fpc = m_pc; m_valid = 1'b0;
            end else if (Branch || Jump) begin
                m_pc = Branch ? Branch_pc : Jump_pc; m_valid = 1'b0;
            end else if (!Stall) begin
                m_instr = w; m_pp4 = m_pc + 4; m_valid = 1'b1;
                if (w == HALTW) m_phase = "HALT";
                else m_pc = m_pc + 4;
            end
        end else begin
            m_valid = 1'b0;
        end
        m_halted = (m_prev == "HALT");
        m_fault  = (m_prev == "FAULT");
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".adress"}, Adress, m_pc);
        check({tag, ".instr"}, Instr, m_instr);
        check({tag, ".pc_plus4"}, Pc_plus4, m_pp4);
        check({tag, ".valid"}, {31'b0, Instr_valid}, {31'b0, m_valid});
        check({tag, ".halted"}, {31'b0, Halted}, {31'b0, m_halted});
        check({tag, ".fault"}, {31'b0, Fault}, {31'b0, m_fault});
        check({tag, ".fault_pc"}, Fault_pc, m_fpc);
        check({tag, ".excl"}, {31'b0, Halted & Fault}, 32'h0);
    endtask

    task automatic step(input string tag);
        @(posedge Clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic idle();
        Stall = 1'b0; Branch = 1'b0; Jump = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        Reset = 1'b1;
        step("rst");
        Reset = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0] = 32'h2008_0001; mem[1] = 32'h2009_0002;
        mem[2] = 32'h0109_5020; mem[3] = 32'h0000_0000;
    endtask

    function automatic logic [31:0] pick_target();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8) return 32'($urandom_range(0, 31)) << 2;
        if (r == 8) return 32'd128;
        return $urandom;
    endfunction

    initial begin
        load_prog();
        model_reset();

        // Reset state, before any clock
        #2;
        compare_all("reset0");
        do_reset();

        // Sequential fetch
        step("boot");
        check("boot.adress", Adress, 32'h0);
        step("seq1");
        check("seq1.instr", Instr, 32'h2008_0001);
        check("seq1.pp4", Pc_plus4, 32'd4);
        step("seq2");
        check("seq2.instr", Instr, 32'h2009_0002);
        step("seq3");
        check("seq3.instr", Instr, 32'h0109_5020);
        check("seq3.adress", Adress, 32'd12);
        step("seq4");
        check("seq4.pp4", Pc_plus4, 32'd16);

        // Stall at PC=8
        do_reset();
        step("s.boot"); step("s.f0"); step("s.f4");
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("stall");
            check("stall.adress", Adress, 32'd8);
            check("stall.instr", Instr, 32'h2009_0002);
        end
        Stall = 1'b0;
        step("s.rel");
        check("s.rel.instr", Instr, 32'h0109_5020);
        check("s.rel.adress", Adress, 32'd12);

        // Branch + Jump + Stall together
        Stall = 1'b1; Branch = 1'b1; Branch_pc = 32'd4; Jump = 1'b1; Jump_pc = 32'd12;
        step("redir");
        check("redir.adress", Adress, 32'd4);
        check("redir.valid", {31'b0, Instr_valid}, 32'h0);
        idle();
        step("redir.next");
        check("redir.next.instr", Instr, 32'h2009_0002);

        // Halt sentinel at 8
        mem[2] = HALTW;
        do_reset();
        step("h.boot"); step("h.f0"); step("h.f4");
        step("h.sent");
        check("h.sent.instr", Instr, HALTW);
        check("h.sent.valid", {31'b0, Instr_valid}, 32'h1);
        step("h.stop");
        check("h.stop.halted", {31'b0, Halted}, 32'h1);
        Branch = 1'b1; Branch_pc = 32'h0;
        step("h.br");
        check("h.br.adress", Adress, 32'd8);
        idle();
        step("h.idle");
        load_prog();

        // Fault via jump to misaligned target
        do_reset();
        step("fj.boot");
        Jump = 1'b1; Jump_pc = 32'd63;
        step("fj.jump");
        idle();
        step("fj.enter"); step("fj.flag");
        check("fj.fault", {31'b0, Fault}, 32'h1);
        check("fj.fpc", Fault_pc, 32'd63);

        // Fault via branch past the end of memory
        do_reset();
        step("fb.boot");
        Branch = 1'b1; Branch_pc = 32'd128;
        step("fb.br");
        idle();
        Stall = 1'b1; Jump = 1'b1; Jump_pc = 32'd0;
        step("fb.enter"); step("fb.flag");
        check("fb.fault", {31'b0, Fault}, 32'h1);
        check("fb.fpc", Fault_pc, 32'd128);
        idle();

        // Asynchronous reset mid-cycle at PC=12
        do_reset();
        step("ar.boot"); step("ar.f0"); step("ar.f4"); step("ar.f8");
        #3;
        Reset = 1'b1;
        #1;
        model_reset();
        compare_all("ar.async");
        check("ar.adress", Adress, 32'h0);
        step("ar.hold");
        Reset = 1'b0;
        step("ar.boot2");
        step("ar.f0b");
        check("ar.f0b.instr", Instr, 32'h2008_0001);

        // Randomized traffic against the model
        for (int i = 0; i < 32; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HALTW : $urandom;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ((m_halted || m_fault) && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 3) == 0)
                    for (int k = 0; k < 32; k++) mem[k] = ($urandom_range(0, 15) == 0) ? HALTW : $urandom;
                do_reset();
            end else begin
                Stall     = ($urandom_range(0, 3) == 0);
                Branch    = ($urandom_range(0, 9) == 0);
                Jump      = ($urandom_range(0, 9) == 0);
                Branch_pc = pick_target();
                Jump_pc   = pick_target();
                step("rnd");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
